// File: rtl/dsp_dma_pkg.sv
// Shared definitions for the inbound/outbound DMA engines.
// State encoding, default geometry and pointer sizing.
package dsp_dma_pkg;

  localparam int DW_DEF = 12;
  localparam int BS_DEF = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

  // Block pointer must also hold BLOCK_SIZE itself.
  function automatic int ptr_w(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/dma_in_controller_if.sv
// Sample stream from the external system into the DMA.
// master drives data/valid, slave returns ready.
interface dma_in_controller_if #(
  parameter int DATA_WIDTH = 12
);

  logic [DATA_WIDTH-1:0] dma_data_in;
  logic                  dma_valid_in;
  logic                  dma_ready_out;

  modport master (
    output dma_data_in,
    output dma_valid_in,
    input  dma_ready_out
  );

  modport slave (
    input  dma_data_in,
    input  dma_valid_in,
    output dma_ready_out
  );

endinterface

// File: rtl/sample_pack_buffer.sv
// Block sample store with flattened read-out.
// Sample i sits at bits [(i+1)*DW-1 -: DW].
module sample_pack_buffer #(
  parameter int DW = 12,
  parameter int BS = 256,
  parameter int AW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [DW-1:0]    wdata_i,
  output logic [DW*BS-1:0] flat_o
);

  logic [DW-1:0] mem_q [BS];

  // Write one entry per accept; whole array clears on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Flatten entries in ascending order, entry 0 at the LSBs.
  always_comb begin
    flat_o = '0;
    for (int i = 0; i < BS; i++) begin
      flat_o[i*DW +: DW] = mem_q[i];
    end
  end

endmodule

// File: rtl/dma_in_controller.sv
// Inbound DMA: fills one block of samples from a valid/ready
// stream and pulses done once the last sample lands.
module dma_in_controller
  import dsp_dma_pkg::*;
#(
  parameter int DATA_WIDTH = DW_DEF,
  parameter int BLOCK_SIZE = BS_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start_dma_in,
  dma_in_controller_if.slave               bus,
  output logic [DATA_WIDTH*BLOCK_SIZE-1:0] input_buffer_flat,
  output logic                             dma_in_busy,
  output logic                             dma_in_done,
  output logic                             dma_in_overrun
);

  localparam int PW = ptr_w(BLOCK_SIZE);
  localparam int AW = addr_w(BLOCK_SIZE);
  localparam logic [PW-1:0] LAST = PW'(BLOCK_SIZE - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          ovr_q, ovr_d;
  logic          ready;
  logic          accept;

  // Ready is a pure decode of state so FILL accepts from its first cycle.
  assign ready  = (state_q == FILL);
  assign accept = ready && bus.dma_valid_in;

  assign bus.dma_ready_out = ready;
  assign dma_in_busy       = (state_q == FILL) || (state_q == DONE);
  assign dma_in_done       = (state_q == DONE);
  assign dma_in_overrun    = ovr_q;

  // State, pointer and sticky overrun registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state: start only in IDLE, advance on accept, one DONE cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (start_dma_in) begin
          ptr_d   = '0;
          ovr_d   = 1'b0;
          state_d = FILL;
        end else if (bus.dma_valid_in) begin
          ovr_d = 1'b1;
        end
      end
      FILL: begin
        if (accept) begin
          ptr_d = ptr_q + PW'(1);
          if (ptr_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.dma_valid_in) ovr_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  sample_pack_buffer #(
    .DW (DATA_WIDTH),
    .BS (BLOCK_SIZE),
    .AW (AW)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .we_i    (accept),
    .waddr_i (ptr_q[AW-1:0]),
    .wdata_i (bus.dma_data_in),
    .flat_o  (input_buffer_flat)
  );

endmodule

// File: tb/tb_dma_in_controller.sv
// Directed bench for dma_in_controller with a 4 x 12-bit block.
// Expected values are hand-computed constants.
module tb_dma_in_controller;

  localparam int DW = 12;
  localparam int BS = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [DW*BS-1:0] flat;
  logic          busy, done, ovr;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  dma_in_controller_if #(.DATA_WIDTH(DW)) bus ();

  dma_in_controller #(
    .DATA_WIDTH (DW),
    .BLOCK_SIZE (BS)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start_dma_in      (start),
    .bus               (bus.slave),
    .input_buffer_flat (flat),
    .dma_in_busy       (busy),
    .dma_in_done       (done),
    .dma_in_overrun    (ovr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.dma_valid_in && bus.dma_ready_out) wr_cnt++;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    bus.dma_data_in  = d;
    bus.dma_valid_in = 1'b1;
    check("send_ready", 64'(bus.dma_ready_out), 64'd1);
    tick();
    bus.dma_valid_in = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int gaps [4] = '{0, 3, 1, 5};

  initial begin
    bus.dma_data_in  = '0;
    bus.dma_valid_in = 1'b0;
    tick();
    tick();
    check("rst_flat", 64'(flat), 64'd0);
    check("rst_ready", 64'(bus.dma_ready_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ovr", 64'(ovr), 64'd0);
    reset = 1'b0;
    tick();

    // back-to-back fill
    do_start();
    bus.dma_valid_in = 1'b1;
    for (int i = 0; i < BS; i++) begin
      bus.dma_data_in = DW'(i + 1);
      check("b2b_ready", 64'(bus.dma_ready_out), 64'd1);
      check("b2b_nodone", 64'(done), 64'd0);
      tick();
    end
    bus.dma_valid_in = 1'b0;
    check("b2b_done", 64'(done), 64'd1);
    check("b2b_busy_done", 64'(busy), 64'd1);
    check("b2b_ready_done", 64'(bus.dma_ready_out), 64'd0);
    check("b2b_flat", 64'(flat), 64'h004_003_002_001);
    tick();
    check("b2b_done_fall", 64'(done), 64'd0);
    check("b2b_busy_fall", 64'(busy), 64'd0);

    // stalled fill, from a cleared buffer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("stl_clear", 64'(flat), 64'd0);
    wr_cnt = 0;
    done_cnt = 0;
    do_start();
    for (int i = 0; i < BS; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        check("stl_ready", 64'(bus.dma_ready_out), 64'd1);
        tick();
      end
      send(DW'(i + 1));
    end
    check("stl_done", 64'(done), 64'd1);
    tick();
    tick();
    check("stl_flat", 64'(flat), 64'h004_003_002_001);
    check("stl_writes", 64'(wr_cnt), 64'd4);
    check("stl_done_cnt", 64'(done_cnt), 64'd1);

    // overrun in IDLE
    bus.dma_data_in  = 12'hABC;
    bus.dma_valid_in = 1'b1;
    tick();
    bus.dma_valid_in = 1'b0;
    check("ovr_set", 64'(ovr), 64'd1);
    check("ovr_flat", 64'(flat), 64'h004_003_002_001);
    tick();
    check("ovr_sticky", 64'(ovr), 64'd1);

    // start clears overrun; start ignored while busy
    done_cnt = 0;
    do_start();
    check("ovr_clear", 64'(ovr), 64'd0);
    send(12'hAAA);
    send(12'hBBB);
    do_start();
    check("ign_busy", 64'(busy), 64'd1);
    send(12'hCCC);
    send(12'hDDD);
    check("ign_done", 64'(done), 64'd1);
    tick();
    check("ign_flat", 64'(flat), 64'hDDD_CCC_BBB_AAA);
    check("ign_done_cnt", 64'(done_cnt), 64'd1);

    // reset mid-fill
    done_cnt = 0;
    do_start();
    send(12'h123);
    send(12'h456);
    reset = 1'b1;
    #2;
    check("mid_flat", 64'(flat), 64'd0);
    check("mid_ready", 64'(bus.dma_ready_out), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("mid_nodone", 64'(done_cnt), 64'd0);
    do_start();
    send(12'h111);
    send(12'h222);
    send(12'h333);
    send(12'h444);
    tick();
    check("mid_refill", 64'(flat), 64'h444_333_222_111);
    check("mid_done_cnt", 64'(done_cnt), 64'd1);

    // retention: partial overwrite of previous block
    do_start();
    send(12'h555);
    check("ret_flat", 64'(flat), 64'h444_333_222_555);
    check("ret_busy", 64'(busy), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
